hsck_frame_responder: RTL
=========================

Name: hsck_frame_responder

Overview:
- Far-end (device-side) partner of the tester's masked-HSCK frame generator.
- Receives the gated high-speed clock (hsck_in) and serial data (sdi) on the system clock.
- Deserializes each 32-bit frame and serializes a preloaded 32-bit response on sdo.
- A frame is two 16-pulse bursts with an 8-period gap; frames are separated by 24 idle HSCK periods. Frame end is detected by idle timeout.

Parameters:
- WORD_BITS, 32, bits per frame, MSB first.
- IDLE_CYCLES, 64, system clocks with no hsck edge that close a frame. Must exceed the intra-frame gap (8 HSCK periods) and be shorter than the inter-frame gap (24 periods); the default assumes clock = 4x HSCK.

Ports:
- clock  input  1  system clock; all logic rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- hsck_in  input  1  masked HSCK, asynchronous; 2-flop synchronized.
- sdi  input  1  serial data in; sampled on the synchronized hsck rising edge, 2-flop synchronized alongside hsck_in.
- sdo  output  1  serial data out; changes after hsck falling edges.
- tx_data  input  WORD_BITS  response word.
- tx_load  input  1  1-cycle strobe; latches tx_data into the holding register.
- tx_pending  output  1  holding register full, not yet consumed by a frame.
- rx_data  output  WORD_BITS  last good received word; held until the next good frame.
- rx_valid  output  1  1-cycle pulse when rx_data updates.
- frame_err  output  1  1-cycle pulse on a bad frame.
- tx_underrun  output  1  sticky; set when a frame starts with tx_pending=0; cleared by tx_load.
- busy  output  1  high while in SHIFT.

Behaviour:
- Reset values: all outputs 0, rx_data 0, hold/shift registers 0, state SYNC.
- Reset is honoured mid-frame: partial data is discarded.
- Edge detect: rise/fall = synchronized-hsck transition. Detection latency is 3 clocks from pin.
- Required ratio: clock >= 4x HSCK.
- State machine:
  - SYNC: idle_cnt counts clocks without an edge; any edge clears it. When idle_cnt reaches IDLE_CYCLES -> IDLE. This stops a reset taken mid-burst from framing a partial burst.
  - IDLE, first rise: enter SHIFT. Same cycle: shift_reg <= hold, tx_pending <= 0, bit_cnt <= 1, capture sdi into rx shift register bit 0.
    - If tx_pending was 0: shift_reg <= 0 and tx_underrun <= 1.
  - SHIFT, each rise: rx_shift <= {rx_shift[WORD_BITS-2:0], sdi}; bit_cnt saturates at WORD_BITS+1.
  - SHIFT, each fall: shift_reg shifts left by 1, zero fill.
  - SHIFT: any edge clears idle_cnt. When idle_cnt reaches IDLE_CYCLES -> DONE.
  - DONE (one cycle) -> IDLE.
    - If bit_cnt == WORD_BITS: rx_data <= rx_shift, rx_valid = 1.
    - Otherwise (short frame, or overrun = WORD_BITS+1): frame_err = 1 and rx_data is unchanged.
- sdo:
  - In SHIFT: sdo = shift_reg[WORD_BITS-1].
  - In IDLE/SYNC/DONE: sdo = hold[WORD_BITS-1] when tx_pending, else 0.
  - The MSB is therefore valid before the first rise.
- tx_load behaviour:
  - Sets tx_pending and loads hold in any state; overwrites an unconsumed word.
  - Coinciding with the frame-start transfer: the old hold is transferred and the new word is kept (tx_pending stays 1).
- The intra-frame gap (8 HSCK periods = 32 clocks at the default ratio) must not close a frame; the two bursts form one word.
- The idle counter saturates at IDLE_CYCLES; it never wraps.

Test Plan:
- Reset, hold hsck low for 64 clocks, tx_load 0xA5A5_0F0F, run one 16+gap(8)+16 frame with sdi = 0x1234_5678 MSB first -> after timeout rx_valid pulse, rx_data=0x12345678, sdo sequence = 0xA5A50F0F MSB first, tx_pending 1->0 at first rise.
- Frame with 31 pulses -> frame_err pulse, no rx_valid, rx_data keeps 0x12345678.
- Frame with 33 pulses -> frame_err pulse, rx_data unchanged.
- Frame with no tx_load -> tx_underrun=1, sdo all 0; subsequent tx_load clears tx_underrun.
- tx_load 0x1111_1111 on the same cycle as the first detected rise (hold=0xFFFF_FFFF) -> sdo shifts 0xFFFFFFFF, tx_pending stays 1, next frame sends 0x11111111.
- Assert reset_n at pulse 10, release with hsck still toggling -> no rx_valid/frame_err for the partial burst; the next full frame after 64 idle clocks is received correctly.

Source files
------------

// File: rtl/hsck_frame_responder.sv
// Device-side responder for masked-HSCK frames: deserializes 32-bit words from sdi
// and shifts a preloaded response word out on sdo, with idle-timeout framing.
module hsck_frame_responder #(
  parameter int WORD_BITS   = 32,
  parameter int IDLE_CYCLES = 64
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 hsck_in,
  input  logic                 sdi,
  output logic                 sdo,
  input  logic [WORD_BITS-1:0] tx_data,
  input  logic                 tx_load,
  output logic                 tx_pending,
  output logic [WORD_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 tx_underrun,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int BW = $clog2(WORD_BITS + 2);

  typedef enum logic [1:0] {
    S_SYNC  = 2'd0,
    S_IDLE  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_hsck_meta, r_hsck_sync, r_hsck_prev;
  logic                 r_sdi_meta, r_sdi_sync;
  logic [IW-1:0]        r_idle_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [WORD_BITS-1:0] r_hold;
  logic                 r_pending;
  logic                 r_underrun;
  logic [WORD_BITS-1:0] r_shift;
  logic [WORD_BITS-1:0] r_rx_shift;
  logic [WORD_BITS-1:0] r_rx_data;
  logic                 w_rise, w_fall, w_edge;
  logic                 w_timeout;
  logic                 w_start;
  logic                 w_word_ok;

  // sdi travels through the same two-flop depth as hsck so it lines up with the rise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hsck_meta <= 1'b0;
      r_hsck_sync <= 1'b0;
      r_hsck_prev <= 1'b0;
      r_sdi_meta  <= 1'b0;
      r_sdi_sync  <= 1'b0;
    end else begin
      r_hsck_meta <= hsck_in;
      r_hsck_sync <= r_hsck_meta;
      r_hsck_prev <= r_hsck_sync;
      r_sdi_meta  <= sdi;
      r_sdi_sync  <= r_sdi_meta;
    end
  end

  assign w_rise    = r_hsck_sync & ~r_hsck_prev;
  assign w_fall    = ~r_hsck_sync & r_hsck_prev;
  assign w_edge    = w_rise | w_fall;
  assign w_timeout = (r_idle_cnt == IW'(IDLE_CYCLES));
  assign w_start   = (r_state == S_IDLE) && w_rise;
  assign w_word_ok = (r_bit_cnt == BW'(WORD_BITS));

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_SYNC;
    else          r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_SYNC:  if (w_timeout) w_next_state = S_IDLE;
      S_IDLE:  if (w_rise)    w_next_state = S_SHIFT;
      S_SHIFT: if (w_timeout) w_next_state = S_DONE;
      S_DONE:                 w_next_state = S_IDLE;
      default:                w_next_state = S_SYNC;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (r_state == S_SHIFT);
    rx_valid  = (r_state == S_DONE) && w_word_ok;
    frame_err = (r_state == S_DONE) && !w_word_ok;
    dbg_state = r_state;
    if (r_state == S_SHIFT) sdo = r_shift[WORD_BITS-1];
    else                    sdo = r_pending & r_hold[WORD_BITS-1];
  end

  // Idle counter saturates so a long quiet period cannot wrap back under the threshold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_idle_cnt <= '0;
    end else if (r_state == S_SYNC || r_state == S_SHIFT) begin
      if (w_edge)          r_idle_cnt <= '0;
      else if (!w_timeout) r_idle_cnt <= r_idle_cnt + 1'b1;
    end else begin
      r_idle_cnt <= '0;
    end
  end

  // A load coinciding with frame start keeps the new word; the old one goes out.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hold     <= '0;
      r_pending  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (tx_load) begin
        r_hold    <= tx_data;
        r_pending <= 1'b1;
      end else if (w_start) begin
        r_pending <= 1'b0;
      end
      if (w_start && !r_pending) r_underrun <= 1'b1;
      else if (tx_load)          r_underrun <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shift    <= '0;
      r_rx_shift <= '0;
      r_bit_cnt  <= '0;
      r_rx_data  <= '0;
    end else begin
      if (w_start) begin
        r_shift    <= r_pending ? r_hold : '0;
        r_rx_shift <= {{(WORD_BITS-1){1'b0}}, r_sdi_sync};
        r_bit_cnt  <= BW'(1);
      end else if (r_state == S_SHIFT) begin
        if (w_fall) r_shift <= {r_shift[WORD_BITS-2:0], 1'b0};
        if (w_rise) begin
          r_rx_shift <= {r_rx_shift[WORD_BITS-2:0], r_sdi_sync};
          if (r_bit_cnt != BW'(WORD_BITS + 1)) r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
      if (r_state == S_DONE && w_word_ok) r_rx_data <= r_rx_shift;
    end
  end

  assign tx_pending  = r_pending;
  assign tx_underrun = r_underrun;
  assign rx_data     = r_rx_data;

endmodule
